// File: rtl/sd_filter_mc.sv
// sd_filter_mc: CHANNELS sinc^ORDER decimators sharing one run-time selectable decimation timebase.
// Optional feature: define SD_FILTER_MC_SAT_EN to saturate each result to OUTPUT_WIDTH instead of wrapping.
module sd_filter_mc #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned ORDER        = 2,
   parameter int unsigned OSR_MAX      = 256,
   parameter int unsigned OSR_DEFAULT  = 200,
   parameter int unsigned OUTPUT_WIDTH = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [CHANNELS-1:0]              data_i,
   input  logic [$clog2(OSR_MAX+1)-1:0]     osr_i,
   input  logic                             sync_i,
   output logic [CHANNELS*OUTPUT_WIDTH-1:0] data_o,
   output logic                             valid_o,
   output logic                             settled_o,
   output logic                             osr_err_o
);
   localparam int unsigned WIDTH   = $clog2(OSR_MAX**ORDER + 1) + 1;
   localparam int unsigned OSR_W   = $clog2(OSR_MAX + 1);
   localparam int unsigned FLUSH_W = $clog2(ORDER + 1);

`ifdef SD_FILTER_MC_SAT_EN
   localparam int unsigned EXT_W = (WIDTH > OUTPUT_WIDTH) ? WIDTH : OUTPUT_WIDTH;
   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;
`endif

   logic [WIDTH-1:0]   integ    [CHANNELS][ORDER];
   logic [WIDTH-1:0]   comb_q   [CHANNELS][ORDER];
   logic [WIDTH-1:0]   comb_d   [CHANNELS][ORDER];
   logic [WIDTH-1:0]   result_c [CHANNELS];
   logic [OSR_W-1:0]   osr_r;
   logic [OSR_W-1:0]   cnt;
   logic [FLUSH_W-1:0] flush_cnt;
   logic               sync_q;
   logic               sync_edge_c;
   logic               dec_c;
   logic               osr_ok_c;

   // Map a WIDTH-bit signed filter result onto the output word.
   function automatic logic [OUTPUT_WIDTH-1:0] to_output(input logic [WIDTH-1:0] r);
`ifdef SD_FILTER_MC_SAT_EN
      logic signed [EXT_W-1:0] ext;
      ext = EXT_W'($signed(r));
      if (ext > SAT_HI) return SAT_HI[OUTPUT_WIDTH-1:0];
      if (ext < SAT_LO) return SAT_LO[OUTPUT_WIDTH-1:0];
      return ext[OUTPUT_WIDTH-1:0];
`else
      return OUTPUT_WIDTH'($signed(r));
`endif
   endfunction

   assign sync_edge_c = sync_i & ~sync_q;
   assign dec_c       = (cnt == (osr_r - OSR_W'(1)));
   assign osr_ok_c    = (osr_i >= OSR_W'(2)) && (osr_i <= OSR_W'(OSR_MAX));

   // Comb chain: each stage differences its input against the value held from the previous decimation.
   always_comb begin
      logic [WIDTH-1:0] acc;
      acc = '0;
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
         acc = integ[ch][ORDER-1];
         for (int k = 0; k < int'(ORDER); k++) begin
            comb_d[ch][k] = acc;
            acc           = acc - comb_q[ch][k];
         end
         result_c[ch] = acc;
      end
   end

   // Integrator cascade: stage 0 maps bits to +/-1, later stages accumulate the previous stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int ch = 0; ch < int'(CHANNELS); ch++)
            for (int k = 0; k < int'(ORDER); k++)
               integ[ch][k] <= '0;
      end else begin
         for (int ch = 0; ch < int'(CHANNELS); ch++) begin
            integ[ch][0] <= integ[ch][0] + (data_i[ch] ? WIDTH'(1) : '1);
            for (int k = 1; k < int'(ORDER); k++)
               integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
         end
      end
   end

   // Comb registers advance on every decimation not pre-empted by a sync edge; outputs only once flushed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_o <= '0;
         for (int ch = 0; ch < int'(CHANNELS); ch++)
            for (int k = 0; k < int'(ORDER); k++)
               comb_q[ch][k] <= '0;
      end else if (dec_c && !sync_edge_c) begin
         for (int ch = 0; ch < int'(CHANNELS); ch++)
            for (int k = 0; k < int'(ORDER); k++)
               comb_q[ch][k] <= comb_d[ch][k];
         if (flush_cnt == '0) begin
            for (int ch = 0; ch < int'(CHANNELS); ch++)
               data_o[ch*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= to_output(result_c[ch]);
         end
      end
   end

   // Timebase, OSR update on sync edges, flush tracking and status strobes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q    <= 1'b0;
         cnt       <= '0;
         osr_r     <= OSR_W'(OSR_DEFAULT);
         flush_cnt <= FLUSH_W'(ORDER);
         settled_o <= 1'b0;
         valid_o   <= 1'b0;
         osr_err_o <= 1'b0;
      end else begin
         sync_q    <= sync_i;
         valid_o   <= 1'b0;
         osr_err_o <= 1'b0;
         if (sync_edge_c) begin
            cnt       <= '0;
            flush_cnt <= FLUSH_W'(ORDER);
            settled_o <= 1'b0;
            if (osr_ok_c) osr_r <= osr_i;
            else          osr_err_o <= 1'b1;
         end else if (dec_c) begin
            cnt <= '0;
            if (flush_cnt != '0) begin
               flush_cnt <= flush_cnt - FLUSH_W'(1);
               if (flush_cnt == FLUSH_W'(1)) settled_o <= 1'b1;
            end else begin
               valid_o <= 1'b1;
            end
         end else begin
            cnt <= cnt + OSR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sd_filter_mc.sv
// tb_sd_filter_mc: scoreboard bench for sd_filter_mc (CHANNELS=4, ORDER=2, OSR_MAX=256, OUTPUT_WIDTH=16).
module tb_sd_filter_mc;
   localparam int CH = 4;
   localparam int OW = 16;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [CH-1:0]   data_i = '0;
   logic [8:0]      osr_i = '0;
   logic            sync_i = 1'b0;
   logic [CH*OW-1:0] data_o;
   logic            valid_o;
   logic            settled_o;
   logic            osr_err_o;

   typedef struct {
      int               cyc;
      logic [CH*OW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   mode [CH];

   sd_filter_mc #(
      .CHANNELS(CH), .ORDER(2), .OSR_MAX(256), .OSR_DEFAULT(200), .OUTPUT_WIDTH(OW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .osr_i(osr_i), .sync_i(sync_i),
      .data_o(data_o), .valid_o(valid_o), .settled_o(settled_o), .osr_err_o(osr_err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Pattern per channel: 0 zeros, 1 ones, 2 alternating, 3 one-in-four.
   function automatic logic pat_bit(input int m, input int c);
      case (m)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (c % 2) == 0;
         default: return (c % 4) == 0;
      endcase
   endfunction

   // Settled sinc^2 value: N^2 * (2*density - 1).
   function automatic int steady(input int m, input int n);
      case (m)
         0:       return -(n * n);
         1:       return n * n;
         2:       return 0;
         default: return -((n * n) / 2);
      endcase
   endfunction

   function automatic logic [OW-1:0] conv(input int v);
`ifdef SD_FILTER_MC_SAT_EN
      if (v > 32767)  return 16'h7fff;
      if (v < -32768) return 16'h8000;
`endif
      return OW'(v);
   endfunction

   function automatic logic [CH*OW-1:0] exp_vec(input int n);
      logic [CH*OW-1:0] v;
      v = '0;
      for (int k = 0; k < CH; k++) v[k*OW +: OW] = conv(steady(mode[k], n));
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         for (int k = 0; k < CH; k++) data_i[k] = pat_bit(mode[k], cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic go_to_cycle(input int t);
      while (cyc < t) step();
   endtask

   task automatic push_run(input int first, input int n, input int last);
      exp_t e;
      for (int c = first; c <= last; c += n) begin
         e.cyc  = c;
         e.data = exp_vec(n);
         sb.push_back(e);
      end
   endtask

   task automatic start_sync(input int osr, input int hold, output int s);
      osr_i  = 9'(osr);
      sync_i = 1'b1;
      s      = cyc;
      repeat (hold) step();
      sync_i = 1'b0;
   endtask

   // Every strobe must match the head of the scoreboard in cycle and data.
   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i && valid_o) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_strobe cycle=%0d got data=%h want no strobe", cyc, data_o);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || data_o !== e.data) begin
                  failures++;
                  $display("FAIL strobe got cycle=%0d data=%h want cycle=%0d data=%h", cyc, data_o, e.cyc, e.data);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      int r;
      repeat (3) step();
      checks++; if (data_o !== '0)      begin failures++; $display("FAIL reset_data got=%h want=0", data_o); end
      checks++; if (valid_o !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL reset_settled got=%b want=0", settled_o); end
      checks++; if (osr_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", osr_err_o); end
      rst_i = 1'b0;
      r = cyc;
      push_run(r + 600, 200, r + 1800);
      go_to_cycle(r + 399);
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL boot_settled_early got=%b want=0", settled_o); end
      go_to_cycle(r + 400);
      checks++; if (settled_o !== 1'b1) begin failures++; $display("FAIL boot_settled got=%b want=1", settled_o); end
      go_to_cycle(r + 1900);
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL boot_missing got=%0d pending want=0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_accepted_osr(input int n);
      int s, last;
      start_sync(n, 1, s);
      checks++; if (osr_err_o !== 1'b0) begin failures++; $display("FAIL accept_err osr=%0d got=%b want=0", n, osr_err_o); end
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL accept_unsettle osr=%0d got=%b want=0", n, settled_o); end
      last = s + 1 + 3 * n + 4 * n;
      push_run(s + 1 + 3 * n, n, last);
      go_to_cycle(s + 2 * n);
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL accept_settled_early osr=%0d got=%b want=0", n, settled_o); end
      go_to_cycle(s + 2 * n + 1);
      checks++; if (settled_o !== 1'b1) begin failures++; $display("FAIL accept_settled osr=%0d got=%b want=1", n, settled_o); end
      go_to_cycle(last + n / 2);
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL accept_missing osr=%0d got=%0d pending want=0", n, sb.size()); end
      sb.delete();
   endtask

   // Rejected ratios pulse osr_err_o, keep OSR 64 and still restart the flush.
   task automatic test_osr_err();
      int s, last, bad;
      for (int i = 0; i < 2; i++) begin
         bad = (i == 0) ? 1 : 300;
         start_sync(bad, 1, s);
         checks++; if (osr_err_o !== 1'b1) begin failures++; $display("FAIL err_pulse osr=%0d got=%b want=1", bad, osr_err_o); end
         checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL err_unsettle osr=%0d got=%b want=0", bad, settled_o); end
         step();
         checks++; if (osr_err_o !== 1'b0) begin failures++; $display("FAIL err_one_cycle osr=%0d got=%b want=0", bad, osr_err_o); end
         last = s + 1 + 3 * 64 + 64;
         push_run(s + 1 + 3 * 64, 64, last);
         go_to_cycle(last + 32);
         checks++; if (sb.size() != 0) begin failures++; $display("FAIL err_missing osr=%0d got=%0d pending want=0", bad, sb.size()); end
         sb.delete();
      end
   endtask

   // Sync on a decimation cycle, again on a flush decimation, the last one held high.
   task automatic test_sync_dec();
      int s0, s1, s2;
      start_sync(64, 1, s0);
      push_run(s0 + 193, 64, s0 + 257);
      go_to_cycle(s0 + 320);
      start_sync(64, 1, s1);
      go_to_cycle(s1 + 64);
      start_sync(100, 4, s2);
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL syncdec_missing got=%0d pending want=0", sb.size()); end
      sb.delete();
      push_run(s2 + 301, 100, s2 + 401);
      go_to_cycle(s2 + 200);
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL syncdec_settled_early got=%b want=0", settled_o); end
      go_to_cycle(s2 + 201);
      checks++; if (settled_o !== 1'b1) begin failures++; $display("FAIL syncdec_settled got=%b want=1", settled_o); end
      go_to_cycle(s2 + 451);
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL syncdec_tail got=%0d pending want=0", sb.size()); end
      sb.delete();
   endtask

   // Mid-cycle reset clears outputs at once and restores OSR 200.
   task automatic test_reset_mid();
      int r;
      #2;
      rst_i = 1'b1;
      #1;
      checks++; if (data_o !== '0)      begin failures++; $display("FAIL midrst_data got=%h want=0", data_o); end
      checks++; if (valid_o !== 1'b0)   begin failures++; $display("FAIL midrst_valid got=%b want=0", valid_o); end
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL midrst_settled got=%b want=0", settled_o); end
      checks++; if (osr_err_o !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b want=0", osr_err_o); end
      step();
      rst_i = 1'b0;
      r = cyc;
      push_run(r + 600, 200, r + 800);
      go_to_cycle(r + 399);
      checks++; if (settled_o !== 1'b0) begin failures++; $display("FAIL midrst_settled_early got=%b want=0", settled_o); end
      go_to_cycle(r + 400);
      checks++; if (settled_o !== 1'b1) begin failures++; $display("FAIL midrst_settled_late got=%b want=1", settled_o); end
      go_to_cycle(r + 900);
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL midrst_missing got=%0d pending want=0", sb.size()); end
      sb.delete();
   endtask

   initial begin
      for (int k = 0; k < CH; k++) mode[k] = 1;
      fork
         monitor_loop();
      join_none
      test_reset();
      mode = '{1, 3, 2, 0};
      test_accepted_osr(100);
      test_accepted_osr(200);
      for (int k = 0; k < CH; k++) mode[k] = 1;
      test_accepted_osr(64);
      test_osr_err();
      test_sync_dec();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
